// File: rtl/masked_rand_gen.sv
// masked_rand_gen: xorshift32-fed buffer handing out HPC1 refresh (r) and pair (p) masks over valid/ready
module masked_rand_gen #(
   parameter int          NUM_SHARES   = 2,
   parameter int          BIT_WIDTH    = 8,
   parameter int          NUM_MULS     = 1,
   parameter logic [31:0] SEED_DEFAULT = 32'h00000001,
   localparam int         NUM_QUAD     = NUM_SHARES * (NUM_SHARES - 1) / 2,
   localparam int         W_R          = NUM_MULS * NUM_SHARES * BIT_WIDTH,
   localparam int         W_P          = NUM_MULS * NUM_QUAD * BIT_WIDTH
) (
   input  logic           in_clock,
   input  logic           in_reset,
   input  logic [31:0]    in_seed,
   input  logic           in_seed_valid,
   output logic [W_R-1:0] out_r,
   output logic [W_P-1:0] out_p,
   output logic           out_valid,
   input  logic           in_ready
);
   localparam int NUM_WORDS = (W_R + W_P + 31) / 32;
   localparam int CW = $clog2(NUM_WORDS + 1);
   localparam logic [CW-1:0] FULL = CW'(NUM_WORDS);

   logic [31:0] x_q, x_d, s1, s2, x_next;
   logic [CW-1:0] count_q, count_d, wr_idx;
   logic [NUM_WORDS*32-1:0] buf_q, buf_d;
   logic valid_q, valid_d;
   logic fire;

   assign s1     = x_q ^ (x_q << 13);
   assign s2     = s1 ^ (s1 >> 17);
   assign x_next = s2 ^ (s2 << 5);
   assign fire   = valid_q & in_ready;
   assign wr_idx = fire ? '0 : count_q;

   // reseed beats fire beats fill; a full, stalled buffer freezes the PRNG
   always_comb begin
      x_d     = x_q;
      count_d = count_q;
      buf_d   = buf_q;
      if (in_seed_valid) begin
         x_d     = (in_seed == 32'd0) ? 32'h2545F491 : in_seed;
         count_d = '0;
      end else if (fire || count_q != FULL) begin
         x_d     = x_next;
         count_d = wr_idx + CW'(1);
         for (int w = 0; w < NUM_WORDS; w++)
            if (wr_idx == CW'(w)) buf_d[w*32 +: 32] = x_next;
      end
      valid_d = (count_d == FULL);
   end

   // state registers; reset drops any partial or pending set
   always_ff @(posedge in_clock or negedge in_reset) begin
      if (!in_reset) begin
         x_q     <= SEED_DEFAULT;
         count_q <= '0;
         buf_q   <= '0;
         valid_q <= 1'b0;
      end else begin
         x_q     <= x_d;
         count_q <= count_d;
         buf_q   <= buf_d;
         valid_q <= valid_d;
      end
   end

   assign out_r     = buf_q[W_R-1:0];
   assign out_p     = buf_q[W_R +: W_P];
   assign out_valid = valid_q;
endmodule

// File: tb/tb_masked_rand_gen.sv
// tb_masked_rand_gen: scoreboard bench for the 1-word and 2-word randomness generator configurations
module tb_masked_rand_gen;
   logic clk = 1'b0;
   logic rst_a, rst_b, sv_a, sv_b, rdy_a, rdy_b, val_a, val_b;
   logic [31:0] seed_a, seed_b;
   logic [15:0] r_a;
   logic [7:0]  p_a;
   logic [31:0] r_b;
   logic [15:0] p_b;
   logic [63:0] q_a[$];
   logic [63:0] q_b[$];
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   masked_rand_gen u_a (
      .in_clock(clk), .in_reset(rst_a), .in_seed(seed_a), .in_seed_valid(sv_a),
      .out_r(r_a), .out_p(p_a), .out_valid(val_a), .in_ready(rdy_a));

   masked_rand_gen #(.NUM_MULS(2)) u_b (
      .in_clock(clk), .in_reset(rst_b), .in_seed(seed_b), .in_seed_valid(sv_b),
      .out_r(r_b), .out_p(p_b), .out_valid(val_b), .in_ready(rdy_b));

   function automatic logic [31:0] xs(input logic [31:0] v);
      logic [31:0] t;
      t = v ^ (v << 13);
      t = t ^ (t >> 17);
      return t ^ (t << 5);
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic push_a(input logic [31:0] w);
      q_a.push_back({40'd0, w[23:0]});
   endtask

   task automatic push_b(input logic [31:0] hi, input logic [31:0] lo);
      q_b.push_back({16'd0, hi[15:0], lo});
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // monitor A: every valid cycle must show the queue head; a taken set retires it
   always @(negedge clk) begin
      if (val_a) begin
         if (q_a.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL a_extra_set: got %h expected none", {p_a, r_a});
         end else begin
            check("a_set", {40'd0, p_a, r_a}, q_a[0]);
            if (rdy_a && !sv_a) void'(q_a.pop_front());
         end
      end
   end

   // monitor B: same scoreboard for the two-multiplier instance
   always @(negedge clk) begin
      if (val_b) begin
         if (q_b.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL b_extra_set: got %h expected none", {p_b, r_b});
         end else begin
            check("b_set", {16'd0, p_b, r_b}, q_b[0]);
            if (rdy_b && !sv_b) void'(q_b.pop_front());
         end
      end
   end

   initial begin
      rst_a = 0; rst_b = 0; sv_a = 0; sv_b = 0;
      rdy_a = 0; rdy_b = 0; seed_a = 0; seed_b = 0;
      repeat (2) tick();
      check("a_reset_valid", {63'd0, val_a}, 64'd0);
      check("a_reset_buf", {40'd0, p_a, r_a}, 64'd0);
      push_a(32'h00042021);
      rst_a = 1;
      #1 check("a_valid_before_edge", {63'd0, val_a}, 64'd0);
      tick();
      check("a_valid_first_edge", {63'd0, val_a}, 64'd1);
      check("a_first_r", {48'd0, r_a}, 64'h2021);
      check("a_first_p", {56'd0, p_a}, 64'h04);
      repeat (5) tick();
      check("a_valid_stalled", {63'd0, val_a}, 64'd1);
      push_a(32'h04080601);
      push_a(32'h9DCCA8C5);
      rdy_a = 1;
      repeat (3) begin
         tick();
         check("a_valid_streaming", {63'd0, val_a}, 64'd1);
      end
      rdy_a = 0;
      push_a(xs(32'h9DCCA8C5));
      tick();
      seed_a = 32'd0; sv_a = 1; rdy_a = 1;
      tick();
      sv_a = 0; rdy_a = 0;
      check("a_valid_after_reseed", {63'd0, val_a}, 64'd0);
      q_a.delete();
      push_a(xs(32'h2545F491));
      tick();
      check("a_valid_reseed_fill", {63'd0, val_a}, 64'd1);
      tick();
      rst_a = 0;
      #1 check("a_async_reset_valid", {63'd0, val_a}, 64'd0);
      check("a_async_reset_buf", {40'd0, p_a, r_a}, 64'd0);
      q_a.delete();
      push_a(32'h00042021);
      tick();
      rst_a = 1;
      tick();
      check("a_valid_after_rerelease", {63'd0, val_a}, 64'd1);
      tick();
      push_b(32'h04080601, 32'h00042021);
      rdy_b = 1; rst_b = 1;
      tick();
      check("b_valid_edge1", {63'd0, val_b}, 64'd0);
      tick();
      check("b_valid_edge2", {63'd0, val_b}, 64'd1);
      push_b(xs(32'h9DCCA8C5), 32'h9DCCA8C5);
      tick();
      rdy_b = 0;
      check("b_valid_gap", {63'd0, val_b}, 64'd0);
      tick();
      check("b_valid_second", {63'd0, val_b}, 64'd1);
      tick();
      rdy_b = 1;
      tick();
      rdy_b = 0;
      check("b_valid_midfill", {63'd0, val_b}, 64'd0);
      seed_b = 32'h00000001; sv_b = 1;
      tick();
      sv_b = 0;
      check("b_valid_after_reseed", {63'd0, val_b}, 64'd0);
      push_b(32'h04080601, 32'h00042021);
      tick();
      check("b_valid_refill1", {63'd0, val_b}, 64'd0);
      tick();
      check("b_valid_refill2", {63'd0, val_b}, 64'd1);
      repeat (2) tick();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
